// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared definitions for the pipeline control blocks. It holds
//               the redirect FSM state encoding, the default address width and
//               the writeback link-select encoding. The MEM-stage writeback mux
//               uses the same link-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // Default width of PC / target addresses.
    localparam int C_DATA_W = 32;

    // Width of the post-redirect drain counter (DRAIN_CYCLES is 0..15).
    localparam int C_DRAIN_W = 4;

    // Writeback mux select encoding.
    localparam logic SEL_ALU  = 1'b0;
    localparam logic SEL_LINK = 1'b1;

    // Redirect sequencer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } redirect_state_t;

    // A control transfer is taken for any valid jump, or for a valid branch
    // whose compare produced zero.
    function automatic logic take_decode(
        input logic valid,
        input logic jump,
        input logic branch,
        input logic zero
    );
        return valid & (jump | (branch & zero));
    endfunction

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/jump_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : jump_redirect_ctrl_if
// Description : Bundles the MEM-stage control inputs, the fetch redirect
//               handshake, the stage flushes, the link select and the status
//               outputs of jump_redirect_ctrl.
//               master : pipeline side (drives mem_* and pc_stall)
//               slave  : the redirect controller
// Revision    : 1.0 - initial release
// ============================================================================
interface jump_redirect_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // MEM stage -> controller
    logic              mem_valid;
    logic              mem_jump;
    logic              mem_branch;
    logic              mem_zero;
    logic [DATA_W-1:0] mem_target;
    // fetch -> controller
    logic              pc_stall;
    // controller -> fetch
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    // controller -> pipeline registers / writeback mux / status
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              flush_ex_mem;
    logic              link_sel;
    logic              busy;
    logic [CNT_W-1:0]  redirect_count;

    modport master (
        output mem_valid, mem_jump, mem_branch, mem_zero, mem_target, pc_stall,
        input  redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
               flush_ex_mem, link_sel, busy, redirect_count
    );

    modport slave (
        input  mem_valid, mem_jump, mem_branch, mem_zero, mem_target, pc_stall,
        output redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
               flush_ex_mem, link_sel, busy, redirect_count
    );

endinterface : jump_redirect_ctrl_if
`default_nettype wire

// File: rtl/jump_redirect_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter for pipeline performance statistics.
//               The count increments on inc and sticks at all-ones. clear is a
//               synchronous zero and has priority over inc.
// Ports       : clk, rst (async, active-high), inc, clear, count[CNT_W]
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    input  wire logic             clear,
    output logic      [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/jump_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jump_redirect_ctrl
// Description : Control-transfer sequencer beside the MEM stage. It detects a
//               taken jump or branch, latches its target, and requests a fetch
//               redirect with a valid/stall handshake. It flushes the
//               wrong-path pipeline registers and drives the writeback link
//               select.
// Ports       : clk            - pipeline clock
//               reset          - asynchronous active-high reset
//               bus (slave)    - mem_* inputs, pc_stall, redirect_valid/pc,
//                                flush_*, link_sel, busy, redirect_count
// Revision    : 1.0 - initial release
// ============================================================================
module jump_redirect_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DATA_W       = C_DATA_W,
    parameter int DRAIN_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    jump_redirect_ctrl_if.slave bus
);

    // Value loaded into the drain counter when a redirect is accepted. DRAIN
    // leaves when the counter reads zero, so DRAIN lasts DRAIN_CYCLES cycles.
    localparam logic [C_DRAIN_W-1:0] C_DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? C_DRAIN_W'(DRAIN_CYCLES - 1) : '0;

    redirect_state_t        r_state;
    redirect_state_t        w_state_next;
    logic [DATA_W-1:0]      r_tgt;
    logic [C_DRAIN_W-1:0]   r_drain_cnt;

    logic                   w_take;
    logic                   w_load_tgt;
    logic                   w_accept;
    logic                   w_load_drain;
    logic                   w_dec_drain;

    assign w_take = take_decode(bus.mem_valid, bus.mem_jump,
                                bus.mem_branch, bus.mem_zero);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_tgt   = 1'b0;
        w_accept     = 1'b0;
        w_load_drain = 1'b0;
        w_dec_drain  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_load_tgt   = 1'b1;
                    w_state_next = REDIRECT;
                end
            end

            // The instruction in MEM here is wrong-path and is killed by
            // flush_ex_mem, so take is not looked at.
            REDIRECT: begin
                if (!bus.pc_stall) begin
                    w_accept = 1'b1;
                    if (DRAIN_CYCLES == 0) begin
                        w_state_next = IDLE;
                    end else begin
                        w_load_drain = 1'b1;
                        w_state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_dec_drain = 1'b1;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Target register and drain counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tgt <= '0;
        end else if (w_load_tgt) begin
            r_tgt <= bus.mem_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drain_cnt <= '0;
        end else if (w_load_drain) begin
            r_drain_cnt <= C_DRAIN_LOAD;
        end else if (w_dec_drain) begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Accepted-redirect counter
    // ------------------------------------------------------------------------
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (w_accept),
        .clear (1'b0),
        .count (bus.redirect_count)
    );

    // ------------------------------------------------------------------------
    // Outputs: everything except link_sel is decoded from registers only.
    // link_sel must follow the jump in MEM in the same cycle, so it is the one
    // combinational output. Outside IDLE the MEM instruction is wrong-path and
    // must not select the link address.
    // ------------------------------------------------------------------------
    assign bus.redirect_valid = (r_state == REDIRECT);
    assign bus.redirect_pc    = r_tgt;
    assign bus.flush_if_id    = (r_state == REDIRECT) || (r_state == DRAIN);
    assign bus.flush_id_ex    = (r_state == REDIRECT);
    assign bus.flush_ex_mem   = (r_state == REDIRECT);
    assign bus.busy           = (r_state != IDLE);
    assign bus.link_sel       = (bus.mem_valid && bus.mem_jump && (r_state == IDLE))
                                ? SEL_LINK : SEL_ALU;

endmodule : jump_redirect_ctrl
`default_nettype wire

// File: tb/tb_jump_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jump_redirect_ctrl
// Description : Self-checking bench for jump_redirect_ctrl. It builds three
//               instances with different drain lengths and counter widths,
//               drives them in lock-step, and compares every output each cycle
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_redirect_ctrl;

    localparam int NDUT = 3;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // shared stimulus
    logic          t_valid, t_jump, t_branch, t_zero, t_stall;
    logic [DW-1:0] t_target;

    jump_redirect_ctrl_if #(.DATA_W(DW), .CNT_W(4))  if0 ();
    jump_redirect_ctrl_if #(.DATA_W(DW), .CNT_W(16)) if1 ();
    jump_redirect_ctrl_if #(.DATA_W(DW), .CNT_W(16)) if2 ();

    assign if0.mem_valid = t_valid;  assign if1.mem_valid = t_valid;  assign if2.mem_valid = t_valid;
    assign if0.mem_jump = t_jump;    assign if1.mem_jump = t_jump;    assign if2.mem_jump = t_jump;
    assign if0.mem_branch = t_branch; assign if1.mem_branch = t_branch; assign if2.mem_branch = t_branch;
    assign if0.mem_zero = t_zero;    assign if1.mem_zero = t_zero;    assign if2.mem_zero = t_zero;
    assign if0.mem_target = t_target; assign if1.mem_target = t_target; assign if2.mem_target = t_target;
    assign if0.pc_stall = t_stall;   assign if1.pc_stall = t_stall;   assign if2.pc_stall = t_stall;

    jump_redirect_ctrl #(.DATA_W(DW), .DRAIN_CYCLES(1), .CNT_W(4))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    jump_redirect_ctrl #(.DATA_W(DW), .DRAIN_CYCLES(0), .CNT_W(16))
        dut1 (.clk(clk), .reset(reset), .bus(if1));
    jump_redirect_ctrl #(.DATA_W(DW), .DRAIN_CYCLES(3), .CNT_W(16))
        dut2 (.clk(clk), .reset(reset), .bus(if2));

    // ---------------- reference model ----------------
    // Per instance: is a redirect outstanding, its target, how many drain
    // cycles remain, and how many redirects fetch has accepted.
    int            drain_len [NDUT] = '{1, 0, 3};
    int            cnt_max   [NDUT] = '{15, 65535, 65535};
    bit            m_pend    [NDUT];
    logic [DW-1:0] m_tgt     [NDUT];
    int            m_drain   [NDUT];
    int            m_cnt     [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_pend[k] = 0; m_tgt[k] = '0; m_drain[k] = 0; m_cnt[k] = 0;
        end
    endtask

    // Advance the model across one rising edge with the current inputs.
    task automatic model_clock();
        bit take;
        take = t_valid && (t_jump || (t_branch && t_zero));
        for (int k = 0; k < NDUT; k++) begin
            if (m_pend[k]) begin
                if (!t_stall) begin
                    if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
                    m_pend[k]  = 0;
                    m_drain[k] = drain_len[k];
                end
            end else if (m_drain[k] > 0) begin
                m_drain[k]--;
            end else if (take) begin
                m_pend[k] = 1;
                m_tgt[k]  = t_target;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // flags = {redirect_valid, flush_if_id, flush_id_ex, flush_ex_mem, link_sel, busy}
    task automatic get_dut(input int k, output logic [31:0] pc, output logic [31:0] cnt,
                           output logic [31:0] flags);
        pc = '0; cnt = '0; flags = '0;
        case (k)
            0: begin
                pc = if0.redirect_pc; cnt = 32'(if0.redirect_count);
                flags = 32'({if0.redirect_valid, if0.flush_if_id, if0.flush_id_ex,
                             if0.flush_ex_mem, if0.link_sel, if0.busy});
            end
            1: begin
                pc = if1.redirect_pc; cnt = 32'(if1.redirect_count);
                flags = 32'({if1.redirect_valid, if1.flush_if_id, if1.flush_id_ex,
                             if1.flush_ex_mem, if1.link_sel, if1.busy});
            end
            default: begin
                pc = if2.redirect_pc; cnt = 32'(if2.redirect_count);
                flags = 32'({if2.redirect_valid, if2.flush_if_id, if2.flush_id_ex,
                             if2.flush_ex_mem, if2.link_sel, if2.busy});
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [31:0] pc, cnt, flags, e_flags;
        bit busy_e;
        for (int k = 0; k < NDUT; k++) begin
            get_dut(k, pc, cnt, flags);
            busy_e  = m_pend[k] || (m_drain[k] > 0);
            e_flags = 32'({m_pend[k], busy_e, m_pend[k], m_pend[k],
                           (!busy_e && t_valid && t_jump), busy_e});
            chk($sformatf("%s.d%0d.flags", tag, k), flags, e_flags);
            chk($sformatf("%s.d%0d.pc", tag, k), pc, m_tgt[k]);
            chk($sformatf("%s.d%0d.cnt", tag, k), cnt, 32'(m_cnt[k]));
        end
    endtask

    // One pipeline cycle: set inputs after the falling edge, check, then clock.
    task automatic step(input string tag, input logic v, input logic j, input logic b,
                        input logic z, input logic [DW-1:0] tgt, input logic st);
        @(negedge clk);
        t_valid = v; t_jump = j; t_branch = b; t_zero = z; t_target = tgt; t_stall = st;
        #1;
        check_all(tag);
        @(posedge clk);
        model_clock();
    endtask

    task automatic idle_step(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] pc, cnt, flags;
        t_valid = 0; t_jump = 0; t_branch = 0; t_zero = 0; t_stall = 0; t_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all("rst");
        reset = 1'b0;

        // Jump without stall: link in N, redirect in N+1, drain, then idle.
        step("jmp_n",  1, 1, 0, 0, 32'h0000_0100, 0);
        get_dut(0, pc, cnt, flags);
        idle_step("jmp_n1");
        get_dut(0, pc, cnt, flags);
        chk("jmp_n1.pc_direct", pc, 32'h100);
        chk("jmp_n1.flags_direct", flags, 32'b111101);
        idle_step("jmp_n2");
        idle_step("jmp_n3");
        idle_step("jmp_n4");
        idle_step("jmp_n5");

        // Branch not taken.
        step("bnt", 1, 0, 1, 0, 32'h0000_0500, 0);
        idle_step("bnt_after");

        // Taken branch held off by fetch for three cycles.
        step("br_t",  1, 0, 1, 1, 32'h0000_0200, 0);
        step("br_s1", 0, 0, 0, 0, 32'h0, 1);
        step("br_s2", 0, 0, 0, 0, 32'h0, 1);
        step("br_s3", 0, 0, 0, 0, 32'h0, 1);
        idle_step("br_acc");
        repeat (4) idle_step("br_drain");

        // Wrong-path jump arriving during REDIRECT and DRAIN is ignored.
        step("wp0", 1, 1, 0, 0, 32'h0000_0100, 1);
        step("wp1", 1, 1, 0, 0, 32'h0000_0300, 1);
        step("wp2", 1, 1, 0, 0, 32'h0000_0300, 0);
        get_dut(0, pc, cnt, flags);
        chk("wp.pc_direct", pc, 32'h100);
        step("wp3", 1, 1, 0, 0, 32'h0000_0300, 0);
        repeat (4) idle_step("wp_drain");

        // Back-to-back jumps: each is honoured as soon as the controller idles.
        repeat (10) step("b2b", 1, 1, 0, 0, $urandom & 32'hFFFF_FFFC, 0);
        repeat (4) idle_step("b2b_drain");

        // Saturate the 4-bit counter of dut0 with 17 accepted redirects.
        for (int i = 0; i < 17; i++) begin
            step("sat_j", 1, 1, 0, 0, 32'(i) << 4, 0);
            idle_step("sat_r");
            idle_step("sat_d");
        end
        repeat (3) idle_step("sat_idle");
        get_dut(0, pc, cnt, flags);
        chk("sat.count_direct", cnt, 32'hF);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 4),
                 $urandom_range(0, 1),
                 $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 9) < 4));
        end

        // Asynchronous reset in the middle of a stalled redirect.
        step("mr_j", 1, 1, 0, 0, 32'h0000_0040, 1);
        while (!(m_pend[0] && m_tgt[0] == 32'h40 && m_drain[0] == 0)) begin
            step("mr_j", 1, 1, 0, 0, 32'h0000_0040, 1);
            if (n_checks > 200000) break;
        end
        step("mr_hold", 0, 0, 0, 0, 32'h0, 1);
        @(negedge clk);
        t_valid = 0; t_jump = 0; t_branch = 0; t_zero = 0; t_stall = 1;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("mr_async");
        get_dut(0, pc, cnt, flags);
        chk("mr_async.flags_direct", flags, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_step("mr_release");
        idle_step("mr_release2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_jump_redirect_ctrl
`default_nettype wire
